// File: rtl/sample_point_generator.sv
// Raster-scans an inclusive pixel bounding box, presenting each position to a point sampler as a
// pair of recFN values and streaming the positions the sampler reports as inside.
module sample_point_generator #(
  parameter int COORD_W = 16,
  parameter int EXP_W   = 8,
  parameter int SIG_W   = 24
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_valid,
  output logic                                 start_ready,
  input  logic [COORD_W-1:0]                   min_x,
  input  logic [COORD_W-1:0]                   max_x,
  input  logic [COORD_W-1:0]                   min_y,
  input  logic [COORD_W-1:0]                   max_y,
  output logic [2*(EXP_W+SIG_W+1)-1:0]         point_out,
  input  logic                                 inside_in,
  output logic                                 frag_valid,
  input  logic                                 frag_ready,
  output logic [COORD_W-1:0]                   frag_x,
  output logic [COORD_W-1:0]                   frag_y,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           state_dbg
);

  localparam int REC_W = EXP_W + SIG_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a request transfers on a cycle where start_valid && start_ready; a fragment
  // transfers on a cycle where frag_valid && frag_ready, and while frag_valid is high without
  // frag_ready the position and every frag_* output hold. Valids never wait on readys.

  // Unsigned integer to recFN. Positive values round toward -inf by truncation, so the low
  // fraction bits are simply dropped when COORD_W exceeds SIG_W; otherwise the result is exact.
  function automatic logic [REC_W-1:0] to_recfn(input logic [COORD_W-1:0] n);
    logic [COORD_W-1:0]         norm;
    logic [COORD_W+SIG_W-3:0]   wide;
    logic [EXP_W-1:0]           msb;
    msb = '0;
    for (int i = 0; i < COORD_W; i++) begin
      if (n[i]) msb = EXP_W'(i);
    end
    norm = n << (COORD_W - 1 - int'(msb));
    wide = {norm[COORD_W-2:0], {(SIG_W-1){1'b0}}};
    if (n == '0) to_recfn = '0;
    else         to_recfn = {1'b0, 1'b1, msb, wide[COORD_W+SIG_W-3 -: SIG_W-1]};
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d;
  logic [COORD_W-1:0] cur_y_q, cur_y_d;
  // y only ever counts upward, so the low y bound lives solely in cur_y's initial load.
  logic [COORD_W-1:0] min_x_q, min_x_d;
  logic [COORD_W-1:0] max_x_q, max_x_d;
  logic [COORD_W-1:0] max_y_q, max_y_d;

  logic advance;
  logic at_last;
  logic box_empty;

  assign box_empty = (min_x > max_x) || (min_y > max_y);
  assign at_last   = (cur_x_q == max_x_q) && (cur_y_q == max_y_q);
  assign advance   = (state_q == SCAN) && (!inside_in || frag_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          min_x_d = min_x;
          max_x_d = max_x;
          max_y_d = max_y;
          cur_x_d = min_x;
          cur_y_d = min_y;
          state_d = box_empty ? DONE : SCAN;
        end
      end
      SCAN: begin
        // End test is equality-only so a box touching the top of the coordinate range never wraps.
        if (advance) begin
          if (at_last) begin
            state_d = DONE;
          end else if (cur_x_q != max_x_q) begin
            cur_x_d = cur_x_q + 1'b1;
          end else begin
            cur_x_d = min_x_q;
            cur_y_d = cur_y_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign state_dbg   = state_q;
  assign frag_valid  = busy && inside_in;
  assign frag_x      = busy ? cur_x_q : '0;
  assign frag_y      = busy ? cur_y_q : '0;
  assign point_out   = busy ? {to_recfn(cur_x_q), to_recfn(cur_y_q)} : '0;

endmodule

// File: doc/sample_point_generator.md
SAMPLE_POINT_GENERATOR -- requirements
Module: sample_point_generator

Interface
REQ-001 SHALL have parameter COORD_W, default 16, the unsigned integer pixel coordinate width.
REQ-002 SHALL have parameter EXP_W, default 8, the recFN exponent width.
REQ-003 SHALL have parameter SIG_W, default 24, the recFN significand width; one recFN value is EXP_W+SIG_W+1 = 33 bits.
REQ-004 SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n input 1, the reset: asynchronous assert, active-low.
REQ-006 SHALL have port start_valid input 1, a bounding-box request is offered.
REQ-007 SHALL have port start_ready output 1, the block accepts a request.
REQ-008 SHALL have ports min_x, max_x, min_y, max_y input COORD_W each, the inclusive bounding box in pixels.
REQ-009 SHALL have port point_out output 66, the sample point {x[65:33], y[32:0]} in recFN(EXP_W,SIG_W), for the point sampler.
REQ-010 SHALL have port inside_in input 1, the sampler's combinational inside verdict for point_out in the same cycle.
REQ-011 SHALL have ports frag_valid output 1, frag_ready input 1, frag_x output COORD_W and frag_y output COORD_W, the covered-pixel stream.
REQ-012 SHALL have port busy output 1, asserted in state SCAN.
REQ-013 SHALL have port done output 1, a one-cycle pulse when a box has finished.

Function
REQ-014 SHALL implement states IDLE, SCAN and DONE.
REQ-015 SHALL drive start_ready=1 only in IDLE.
REQ-016 SHALL, on start_valid&&start_ready, latch all four box bounds, load cur_x=min_x and cur_y=min_y, and go to SCAN.
REQ-017 SHALL treat a box with min_x>max_x or min_y>max_y as empty: go IDLE->DONE directly, emitting no point and no fragment.
REQ-018 SHALL generate point_out in SCAN by exact unsigned-integer-to-recFN conversion of the registered cur_x and cur_y (HardFloat iNToRecFN, rounding mode round_min), purely combinationally from the registers.
REQ-019 SHALL, in SCAN, drive frag_valid=inside_in, frag_x=cur_x and frag_y=cur_y.
REQ-020 SHALL advance the scan position when in SCAN and either inside_in==0 or frag_ready==1.
REQ-021 SHALL hold cur_x, cur_y and all frag_* outputs stable while frag_valid&&!frag_ready.
REQ-022 SHALL advance in raster order: if cur_x!=max_x then cur_x+1; else cur_x=min_x and cur_y+1.
REQ-023 SHALL make the end-of-box test equality-based (cur_x==max_x && cur_y==max_y) before any increment, so that max=2^COORD_W-1 never wraps.
REQ-024 SHALL, when the last position advances, go SCAN->DONE.
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle and then go to IDLE.
REQ-026 SHALL give a throughput of one position per cycle absent backpressure; the first point_out is valid the cycle after acceptance.
REQ-027 SHALL drive point_out=0, frag_valid=0 and busy=0 outside SCAN.
REQ-028 SHALL ignore start_valid outside IDLE.

Reset
REQ-029 SHALL, while rst_n=0 (including mid-scan), immediately force state=IDLE, cur_x=cur_y=0, latched bounds=0, start_ready=1, busy=0, done=0, frag_valid=0, frag_x=frag_y=0 and point_out=0.
REQ-030 SHALL, after rst_n deasserts, accept a new request in the first IDLE cycle.

Verification
REQ-031 SHALL be verified with box (2,3)x(5,6) and inside_in tied 1, frag_ready=1 -> fragments (2,5),(3,5),(2,6),(3,6) on 4 consecutive cycles, done pulse on the 5th, point_out x for (3,_) = recFN of 3.0.
REQ-032 SHALL be verified with a real point sampler attached for triangle (0,0),(8,0),(0,8), box 0..8 -> fragment count equals the strict-interior pixel count, and no edge pixels are emitted.
REQ-033 SHALL be verified with frag_ready held 0 for 3 cycles on the first inside pixel -> frag_x/frag_y/point_out stable for 3 cycles, then scanning resumes with no pixel lost or repeated.
REQ-034 SHALL be verified with empty box min_x=5, max_x=4 -> no frag_valid, done one cycle after acceptance, busy never 1.
REQ-035 SHALL be verified with box x=y=65534..65535 -> exactly 4 positions, then DONE, with no wrap to 0.
REQ-036 SHALL be verified with rst_n pulsed low mid-scan -> outputs at reset values asynchronously; a following request scans its full box from min.
